// File: rtl/target_feeder_pkg.sv
// target_feeder_pkg: base encodings, per-slot FSM states and default gap length shared by the feeder.
package target_feeder_pkg;
  typedef enum logic [1:0] {BASE_T = 2'b00, BASE_C = 2'b01, BASE_A = 2'b10, BASE_G = 2'b11} base_t;
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP} state_t;
  localparam int GAP_DEFAULT = 2;
endpackage

// File: rtl/base_fifo.sv
// base_fifo: synchronous FIFO of {base, last} entries with count-based full/empty.
module base_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [2:0] din,
  output logic [2:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [2:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/target_feeder.sv
// target_feeder: buffers target bases into two slots and streams them to the scoring array,
// servicing the slot selected by toggle_in each cycle.
module target_feeder
  import target_feeder_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = GAP_DEFAULT,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [1:0]           s_base,
  input  logic                 s_sel,
  input  logic                 s_last,
  input  logic                 ready_in,
  input  logic                 toggle_in,
  output logic [1:0]           data_out,
  output logic                 en0,
  output logic                 en1,
  output logic [CNT_WIDTH-1:0] len0,
  output logic [CNT_WIDTH-1:0] len1,
  output logic                 underrun
);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  logic [2:0] fdout [2];
  logic [1:0] full, empty, push, pop;
  state_t st [2], st_n [2];
  logic [1:0] done, done_n, en, en_n;
  logic [GW-1:0] gcnt [2], gcnt_n [2];
  logic [CNT_WIDTH-1:0] len [2], len_n [2];
  logic [1:0] data_n;
  logic und_n;
  assign s_ready = !full[s_sel];
  assign {en1, en0} = en;
  assign len0 = len[0];
  assign len1 = len[1];
  for (genvar i = 0; i < 2; i++) begin : g_slot
    assign push[i] = s_valid && s_ready && s_sel == 1'(i);
    base_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(push[i]), .pop(pop[i]),
      .din({s_base, s_last}), .dout(fdout[i]), .full(full[i]), .empty(empty[i])
    );
  end
  always_ff @(posedge clk)
    if (!rst) begin
      st <= '{default: S_IDLE};
      gcnt <= '{default: '0};
      len <= '{default: '0};
      done <= '0;
      en <= '0;
      data_out <= BASE_T;
      underrun <= 1'b0;
    end else begin
      st <= st_n;
      gcnt <= gcnt_n;
      len <= len_n;
      done <= done_n;
      en <= en_n;
      data_out <= data_n;
      underrun <= und_n;
    end
  // Only the owned slot moves; data_out always reflects what the owner issued (00 if nothing).
  always_comb begin
    st_n = st;
    gcnt_n = gcnt;
    len_n = len;
    done_n = done;
    en_n = en;
    pop = '0;
    data_n = BASE_T;
    und_n = underrun;
    for (int k = 0; k < 2; k++)
      if (toggle_in == 1'(k))
        case (st[k])
          S_IDLE:
            if (ready_in && !empty[k]) begin
              pop[k] = 1'b1;
              data_n = fdout[k][2:1];
              done_n[k] = fdout[k][0];
              en_n[k] = 1'b1;
              len_n[k] = CNT_WIDTH'(1);
              st_n[k] = S_STREAM;
            end
          S_STREAM:
            if (done[k]) begin
              en_n[k] = 1'b0;
              gcnt_n[k] = GW'(GAP_CYCLES - 1);
              st_n[k] = GAP_CYCLES > 1 ? S_GAP : S_IDLE;
            end else if (!empty[k]) begin
              pop[k] = 1'b1;
              data_n = fdout[k][2:1];
              done_n[k] = fdout[k][0];
              len_n[k] = &len[k] ? len[k] : len[k] + 1'b1;
            end else
              und_n = 1'b1;
          S_GAP:
            if (gcnt[k] <= GW'(1)) st_n[k] = S_IDLE;
            else gcnt_n[k] = gcnt[k] - 1'b1;
          default: st_n[k] = S_IDLE;
        endcase
  end
endmodule

// File: tb/tb_target_feeder.sv
// tb_target_feeder: directed tables, hand sequences and random traffic against a queue-based model.
module tb_target_feeder;
  import target_feeder_pkg::*;
  localparam int DEPTH = 16, GAP = 2, CW = 4, LMAX = (1 << CW) - 1;
  logic clk = 0, rst = 0, s_valid = 0, s_sel = 0, s_last = 0, ready_in = 0, toggle_in = 0;
  logic [1:0] s_base = 0, data_out;
  logic s_ready, en0, en1, underrun;
  logic [CW-1:0] len0, len1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  target_feeder #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_base(s_base),
    .s_sel(s_sel), .s_last(s_last), .ready_in(ready_in), .toggle_in(toggle_in),
    .data_out(data_out), .en0(en0), .en1(en1), .len0(len0), .len1(len1), .underrun(underrun)
  );
  // Reference: each slot is a queue of {base,last} plus "streaming", "last seen" and gap countdown.
  logic [2:0] mq [2][$];
  bit m_act [2], m_fin [2];
  int m_gap [2], m_len [2], m_en [2];
  int m_data;
  bit m_und;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      m_act[k] = 0;
      m_fin[k] = 0;
      m_gap[k] = 0;
      m_len[k] = 0;
      m_en[k] = 0;
    end
    m_data = 0;
    m_und = 0;
  endtask
  task automatic model_step();
    int k;
    bit rdy_pre;
    logic [2:0] e;
    k = int'(toggle_in);
    rdy_pre = mq[s_sel].size() < DEPTH;
    if (!rst) begin
      model_reset();
      return;
    end
    m_data = 0;
    if (m_gap[k] > 0) m_gap[k]--;
    else if (!m_act[k]) begin
      if (ready_in && mq[k].size() > 0) begin
        e = mq[k].pop_front();
        m_act[k] = 1;
        m_en[k] = 1;
        m_len[k] = 1;
        m_fin[k] = e[0];
        m_data = int'(e[2:1]);
      end
    end else if (m_fin[k]) begin
      m_act[k] = 0;
      m_en[k] = 0;
      m_gap[k] = GAP - 1;
    end else if (mq[k].size() > 0) begin
      e = mq[k].pop_front();
      m_len[k] = m_len[k] < LMAX ? m_len[k] + 1 : LMAX;
      m_fin[k] = e[0];
      m_data = int'(e[2:1]);
    end else m_und = 1;
    if (s_valid && rdy_pre) mq[s_sel].push_back({s_base, s_last});
  endtask
  task automatic tick(input bit r, input bit v, input logic [1:0] b, input bit sl, input bit l,
                      input bit rd, input bit tg);
    @(negedge clk);
    rst = r; s_valid = v; s_base = b; s_sel = sl; s_last = l; ready_in = rd; toggle_in = tg;
    #1 chk("s_ready", 32'(s_ready), 32'(mq[sl].size() < DEPTH));
    @(posedge clk);
    model_step();
    #1;
    chk("data_out", 32'(data_out), 32'(m_data));
    chk("en0", 32'(en0), 32'(m_en[0]));
    chk("en1", 32'(en1), 32'(m_en[1]));
    chk("len0", 32'(len0), 32'(m_len[0]));
    chk("len1", 32'(len1), 32'(m_len[1]));
    chk("underrun", 32'(underrun), 32'(m_und));
  endtask
  typedef struct {
    bit v; logic [1:0] b; bit l; bit rd; bit tg;
    int data; int e0; int e1; int l0;
  } vec_t;
  vec_t tbl [11];
  int exp38 [6];
  initial begin
    int f0, f1;
    bit p0, p1;
    repeat (2) @(posedge clk);
    model_reset();
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_en", 32'({en1, en0}), 0);
    chk("rst_len", 32'({len1, len0}), 0);
    chk("rst_und", 32'(underrun), 0);
    chk("rst_s_ready", 32'(s_ready), 1);
    // Slot 0 sequence A,C,G,T with last on T.
    tbl[0]  = '{1, 2'b10, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 2'b01, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 2'b11, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 2'b00, 1, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 2'b00, 0, 1, 0, 2, 1, 0, 1};
    tbl[5]  = '{0, 2'b00, 0, 1, 0, 1, 1, 0, 2};
    tbl[6]  = '{0, 2'b00, 0, 1, 0, 3, 1, 0, 3};
    tbl[7]  = '{0, 2'b00, 0, 1, 0, 0, 1, 0, 4};
    tbl[8]  = '{0, 2'b00, 0, 1, 0, 0, 0, 0, 4};
    tbl[9]  = '{0, 2'b00, 0, 1, 0, 0, 0, 0, 4};
    tbl[10] = '{0, 2'b00, 0, 1, 1, 0, 0, 0, 4};
    for (int i = 0; i < 11; i++) begin
      tick(1, tbl[i].v, tbl[i].b, 0, tbl[i].l, tbl[i].rd, tbl[i].tg);
      chk($sformatf("tbl%0d_data", i), 32'(data_out), tbl[i].data);
      chk($sformatf("tbl%0d_en0", i), 32'(en0), tbl[i].e0);
      chk($sformatf("tbl%0d_en1", i), 32'(en1), tbl[i].e1);
      chk($sformatf("tbl%0d_len0", i), 32'(len0), tbl[i].l0);
    end
    // Interleaved AAAA on slot 0 and GGG on slot 1.
    tick(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 1, 2'b10, 0, i == 3, 0, 0);
    for (int i = 0; i < 3; i++) tick(1, 1, 2'b11, 1, i == 2, 0, 1);
    f0 = -1; f1 = -1; p0 = 0; p1 = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, 0, 0, 0, 1, 1'(i));
      if (i < 7) chk($sformatf("ilv_data%0d", i), 32'(data_out), (i % 2) ? 3 : 2);
      if (p0 && !en0 && f0 < 0) f0 = i;
      if (p1 && !en1 && f1 < 0) f1 = i;
      p0 = en0; p1 = en1;
    end
    chk("ilv_en1_fall", 32'(f1), 7);
    chk("ilv_en0_fall", 32'(f0), 8);
    chk("ilv_len0", 32'(len0), 4);
    chk("ilv_len1", 32'(len1), 3);
    // ready_in low holds slot 0 idle; start waits for an owned cycle.
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(1, 1, 2'b10, 0, 0, 0, 0);
    tick(1, 1, 2'b01, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0, 0, 0, 0);
      chk("rdy_low_en0", 32'(en0), 0);
    end
    tick(1, 0, 0, 0, 0, 1, 1);
    chk("rdy_not_owned_en0", 32'(en0), 0);
    tick(1, 0, 0, 0, 0, 1, 0);
    chk("rdy_start_en0", 32'(en0), 1);
    chk("rdy_start_data", 32'(data_out), 2);
    // Slot 1 starvation after two bases without last.
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(1, 1, 2'b11, 1, 0, 0, 1);
    tick(1, 1, 2'b01, 1, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 1, 1);
    chk("starve_d0", 32'({en1, data_out}), 32'b111);
    tick(1, 0, 0, 0, 0, 1, 1);
    chk("starve_d1", 32'({en1, data_out, underrun}), 32'b1010);
    tick(1, 0, 0, 0, 0, 1, 1);
    chk("starve_und", 32'({en1, data_out, underrun}), 32'b1001);
    tick(1, 0, 0, 0, 0, 1, 0);
    chk("starve_sticky0", 32'({en1, underrun}), 32'b11);
    tick(1, 0, 0, 0, 0, 1, 1);
    chk("starve_sticky1", 32'({en1, data_out, underrun}), 32'b1001);
    chk("starve_len1", 32'(len1), 2);
    // Fill slot 0, then pop-only, push+pop, push-only.
    tick(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) tick(1, 1, 2'(i), 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    chk("full_sel0", 32'(s_ready), 0);
    tick(1, 0, 0, 1, 0, 0, 0);
    chk("full_sel1", 32'(s_ready), 1);
    tick(1, 1, 2'b11, 0, 0, 1, 0);
    chk("pop_only_ready", 32'(s_ready), 1);
    tick(1, 1, 2'b11, 0, 0, 1, 0);
    chk("push_pop_ready", 32'(s_ready), 1);
    tick(1, 1, 2'b11, 0, 0, 1, 1);
    chk("push_only_full", 32'(s_ready), 0);
    // Back-to-back slot 0 sequences, then reset mid-stream.
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(1, 1, 2'b10, 0, 0, 0, 0);
    tick(1, 1, 2'b01, 0, 1, 0, 0);
    tick(1, 1, 2'b11, 0, 0, 0, 0);
    tick(1, 1, 2'b00, 0, 1, 0, 0);
    exp38 = '{1, 1, 0, 0, 1, 1};
    for (int i = 0; i < 6; i++) begin
      tick(1, 0, 0, 0, 0, 1, 0);
      chk($sformatf("b2b_en0_%0d", i), 32'(en0), 32'(exp38[i]));
    end
    tick(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 1, 2'b10, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 1, 0);
    tick(1, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 1, 0);
    chk("midrst_out", 32'({data_out, en1, en0, underrun}), 0);
    chk("midrst_len", 32'({len1, len0}), 0);
    chk("midrst_ready", 32'(s_ready), 1);
    tick(1, 0, 0, 0, 0, 1, 0);
    chk("midrst_discard", 32'(en0), 0);
    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0, 1'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
